pokey_pot_scan: RTL and testbench

- Paddle/potentiometer digitiser stage of POKEY. It sits directly upstream of the POT0..POT7/ALLPOT register read mux.
- Consumes the 8 comparator lines (pot_scan) and a POTGO write strobe.
- Runs the 0..228 scan counter, drives the per-pot capacitor release lines, and latches each pot's count when its comparator trips.

---
 rtl/pokey_pkg.sv | 15 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pokey_pot_scan.sv | 121 ++++++++++++
 tb/tb_pokey_pot_scan.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pokey_pkg.sv
// Shared POKEY types and constants for the pot digitiser and its register map.
package pokey_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } pot_state_t;

    localparam logic [7:0] POT_MAX_DEFAULT = 8'd228;

    // POTGO sits at offset $B of the POKEY write map ($D20B).
    localparam logic [3:0] POTGO_ADDR = 4'hB;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchroniser for asynchronous level inputs (pots, triggers, keyboard).
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pokey_pot_scan.sv
// POKEY paddle digitiser: scan counter, capacitor release control and per-pot count latch.
// Optional macro POT_FAST_SCAN_EN lets fast_scan advance the scan on every o2 cycle.
//
// state | meaning
// IDLE  | after reset, capacitors dumped, counter at 0
// SCAN  | capacitors released, counting ticks and latching tripped pots
// DONE  | scan finished, counts and counter frozen until next POTGO
module pokey_pot_scan
    import pokey_pkg::*;
#(
    parameter logic [7:0] POT_MAX     = POT_MAX_DEFAULT,
    parameter int         NUM_POTS    = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  o2,
    input  logic                  rst_L,
    input  logic                  potgo_strobe,
    input  logic                  clk15_en,
    input  logic                  fast_scan,
    input  logic [NUM_POTS-1:0]   pot_scan,
    output logic [NUM_POTS-1:0]   pot_rel,
    output logic [8*NUM_POTS-1:0] pot_val,
    output logic [NUM_POTS-1:0]   allpot,
    output logic [7:0]            bin_ctr_pot,
    output logic                  scan_done
);

    pot_state_t            state, state_nxt;
    logic [7:0]            ctr_nxt;
    logic [8*NUM_POTS-1:0] val_nxt;
    logic [NUM_POTS-1:0]   allpot_nxt, rel_nxt, trip, psync;
    logic                  done_nxt, tick;

`ifdef POT_FAST_SCAN_EN
    assign tick = fast_scan | clk15_en;
`else
    logic unused_fast_scan;
    assign unused_fast_scan = fast_scan;
    assign tick = clk15_en;
`endif

    sync_2ff #(
        .WIDTH(NUM_POTS),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (o2),
        .rst_n(rst_L),
        .d    (pot_scan),
        .q    (psync)
    );

    always_ff @(posedge o2 or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            bin_ctr_pot <= 8'd0;
            pot_val     <= '0;
            allpot      <= '0;
            pot_rel     <= '0;
            scan_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bin_ctr_pot <= ctr_nxt;
            pot_val     <= val_nxt;
            allpot      <= allpot_nxt;
            pot_rel     <= rel_nxt;
            scan_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ctr_nxt    = bin_ctr_pot;
        val_nxt    = pot_val;
        allpot_nxt = allpot;
        rel_nxt    = pot_rel;
        done_nxt   = 1'b0;
        trip       = allpot & psync;

        case (state)
            SCAN: begin
                // A POTGO write restarts the scan and wins over any tick in the same cycle.
                if (potgo_strobe) begin
                    ctr_nxt    = 8'd0;
                    allpot_nxt = '1;
                    rel_nxt    = '1;
                end else if (tick) begin
                    for (int n = 0; n < NUM_POTS; n++) begin
                        if (trip[n]) val_nxt[8*n +: 8] = bin_ctr_pot;
                    end
                    if (bin_ctr_pot == POT_MAX) begin
                        for (int n = 0; n < NUM_POTS; n++) begin
                            if (allpot[n]) val_nxt[8*n +: 8] = POT_MAX;
                        end
                        allpot_nxt = '0;
                        rel_nxt    = '0;
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        allpot_nxt = allpot & ~trip;
                        rel_nxt    = pot_rel & ~trip;
                        ctr_nxt    = bin_ctr_pot + 8'd1;
                        if ((allpot & ~trip) == '0) begin
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
            end
            default: begin
                rel_nxt = '0;
                if (potgo_strobe) begin
                    state_nxt  = SCAN;
                    ctr_nxt    = 8'd0;
                    allpot_nxt = '1;
                    rel_nxt    = '1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pokey_pot_scan.sv
// Self-checking bench for pokey_pot_scan: fixed vector table, directed scans and random traffic vs a reference model.
module tb_pokey_pot_scan;

    localparam int NP   = 8;
    localparam int PMAX = 228;

    logic          o2 = 1'b0;
    logic          rst_L = 1'b0;
    logic          potgo_strobe = 1'b0;
    logic          clk15_en = 1'b0;
    logic          fast_scan = 1'b0;
    logic [NP-1:0] pot_scan = '0;
    logic [NP-1:0] pot_rel;
    logic [8*NP-1:0] pot_val;
    logic [NP-1:0] allpot;
    logic [7:0]    bin_ctr_pot;
    logic          scan_done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 o2 = ~o2;

    pokey_pot_scan dut (
        .o2          (o2),
        .rst_L       (rst_L),
        .potgo_strobe(potgo_strobe),
        .clk15_en    (clk15_en),
        .fast_scan   (fast_scan),
        .pot_scan    (pot_scan),
        .pot_rel     (pot_rel),
        .pot_val     (pot_val),
        .allpot      (allpot),
        .bin_ctr_pot (bin_ctr_pot),
        .scan_done   (scan_done)
    );

    // Reference model: scan position, per-pot result and "still waiting" flags.
    int            m_cnt;
    int            m_val[NP];
    logic [NP-1:0] m_wait;
    bit            m_running;
    bit            m_done;
    logic [NP-1:0] m_hist[2];

    task automatic model_reset();
        m_cnt = 0;
        foreach (m_val[i]) m_val[i] = 0;
        m_wait = '0;
        m_running = 0;
        m_done = 0;
        m_hist[0] = '0;
        m_hist[1] = '0;
    endtask

    task automatic model_edge();
        logic [NP-1:0] seen;
        bit tk;
        seen = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = pot_scan;
        tk = clk15_en;
`ifdef POT_FAST_SCAN_EN
        if (fast_scan) tk = 1;
`endif
        m_done = 0;
        if (potgo_strobe) begin
            m_running = 1;
            m_cnt = 0;
            m_wait = '1;
        end else if (m_running && tk) begin
            for (int i = 0; i < NP; i++) begin
                if (m_wait[i] && seen[i]) begin
                    m_val[i] = m_cnt;
                    m_wait[i] = 1'b0;
                end
            end
            if (m_cnt == PMAX) begin
                for (int i = 0; i < NP; i++) if (m_wait[i]) m_val[i] = PMAX;
                m_wait = '0;
                m_running = 0;
                m_done = 1;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_wait == '0) begin
                    m_running = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    function automatic logic [63:0] model_vals();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[8*i +: 8] = m_val[i][7:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("allpot", 64'(allpot), 64'(m_wait));
        check("pot_rel", 64'(pot_rel), 64'(m_wait));
        check("bin_ctr_pot", 64'(bin_ctr_pot), 64'(m_cnt[7:0]));
        check("scan_done", 64'(scan_done), 64'(m_done));
        check("pot_val", 64'(pot_val), model_vals());
    endtask

    task automatic cyc();
        @(posedge o2);
        model_edge();
        #1;
        compare();
    endtask

    typedef struct {
        logic       potgo;
        logic       tk;
        logic [7:0] ps;
        logic [7:0] allp;
        logic [7:0] ctr;
        logic       done;
        logic [7:0] p0;
        logic [7:0] p7;
    } vec_t;

    vec_t tv[12];
    int   dones;

    initial begin
        tv[0]  = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'd0, 1'b0, 8'd0, 8'd0};
        tv[1]  = '{1'b0, 1'b1, 8'h01, 8'hFF, 8'd1, 1'b0, 8'd0, 8'd0};
        tv[2]  = '{1'b0, 1'b1, 8'h01, 8'hFF, 8'd2, 1'b0, 8'd0, 8'd0};
        tv[3]  = '{1'b0, 1'b1, 8'h01, 8'hFE, 8'd3, 1'b0, 8'd2, 8'd0};
        tv[4]  = '{1'b0, 1'b0, 8'h80, 8'hFE, 8'd3, 1'b0, 8'd2, 8'd0};
        tv[5]  = '{1'b0, 1'b0, 8'h80, 8'hFE, 8'd3, 1'b0, 8'd2, 8'd0};
        tv[6]  = '{1'b0, 1'b1, 8'h80, 8'h7E, 8'd4, 1'b0, 8'd2, 8'd3};
        tv[7]  = '{1'b1, 1'b1, 8'h80, 8'hFF, 8'd0, 1'b0, 8'd2, 8'd3};
        tv[8]  = '{1'b0, 1'b1, 8'hFF, 8'h7F, 8'd1, 1'b0, 8'd2, 8'd0};
        tv[9]  = '{1'b0, 1'b1, 8'hFF, 8'h7F, 8'd2, 1'b0, 8'd2, 8'd0};
        tv[10] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'd3, 1'b1, 8'd2, 8'd0};
        tv[11] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'd3, 1'b0, 8'd2, 8'd0};

        model_reset();
        repeat (3) @(posedge o2);
        #1;
        compare();
        rst_L = 1'b1;

        // Idle: nothing may move without POTGO.
        repeat (1000) cyc();
        check("idle_rel", 64'(pot_rel), 64'h0);
        check("idle_allpot", 64'(allpot), 64'h0);
        check("idle_val", 64'(pot_val), 64'h0);
        check("idle_ctr", 64'(bin_ctr_pot), 64'h0);

        for (int i = 0; i < 12; i++) begin
            potgo_strobe = tv[i].potgo;
            clk15_en     = tv[i].tk;
            pot_scan     = tv[i].ps;
            cyc();
            check("tv_allpot", 64'(allpot), 64'(tv[i].allp));
            check("tv_ctr", 64'(bin_ctr_pot), 64'(tv[i].ctr));
            check("tv_done", 64'(scan_done), 64'(tv[i].done));
            check("tv_pot0", 64'(pot_val[7:0]), 64'(tv[i].p0));
            check("tv_pot7", 64'(pot_val[63:56]), 64'(tv[i].p7));
        end

        // Full-length scan, pot0 trips after tick 50 and is seen two cycles later.
        potgo_strobe = 0; clk15_en = 0; pot_scan = '0;
        repeat (3) cyc();
        potgo_strobe = 1; clk15_en = 1;
        cyc();
        potgo_strobe = 0;
        dones = 0;
        for (int k = 1; k <= 240; k++) begin
            cyc();
            if (scan_done) dones++;
            if (k == 50) pot_scan = 8'h01;
        end
        check("full_done_count", 64'(dones), 64'd1);
        check("full_pot0", 64'(pot_val[7:0]), 64'd52);
        check("full_pot5", 64'(pot_val[47:40]), 64'd228);
        check("full_ctr", 64'(bin_ctr_pot), 64'd228);
        check("full_allpot", 64'(allpot), 64'h0);
        check("full_rel", 64'(pot_rel), 64'h0);

        // Restart on a tick cycle while pot2's comparator is just arriving.
        pot_scan = '0;
        repeat (3) cyc();
        potgo_strobe = 1;
        cyc();
        potgo_strobe = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (k == 98) pot_scan = 8'h04;
        end
        check("pre_restart_ctr", 64'(bin_ctr_pot), 64'd100);
        potgo_strobe = 1;
        cyc();
        potgo_strobe = 0;
        check("restart_ctr", 64'(bin_ctr_pot), 64'd0);
        check("restart_allpot", 64'(allpot), 64'hFF);
        check("restart_pot2_kept", 64'(pot_val[23:16]), 64'd228);
        check("restart_pot0_kept", 64'(pot_val[7:0]), 64'd52);
        cyc();
        check("after_restart_pot2", 64'(pot_val[23:16]), 64'd0);
        check("after_restart_allpot", 64'(allpot), 64'hFB);
        pot_scan = 8'hFF;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (scan_done) dones++;
        end
        check("early_done_count", 64'(dones), 64'd1);

        // Random traffic against the model.
        pot_scan = '0;
        for (int k = 0; k < 6000; k++) begin
            potgo_strobe = ($urandom_range(0, 799) == 0);
            clk15_en     = ($urandom_range(0, 2) == 0);
            fast_scan    = 1'($urandom_range(0, 1));
            if (potgo_strobe) pot_scan = '0;
            else if ($urandom_range(0, 299) == 0) pot_scan[$urandom_range(0, NP-1)] = 1'b1;
            cyc();
        end
        fast_scan = 0;

        // Asynchronous reset in the middle of a scan.
        potgo_strobe = 0; clk15_en = 1; pot_scan = '0;
        repeat (3) cyc();
        potgo_strobe = 1;
        cyc();
        potgo_strobe = 0;
        pot_scan = 8'h10;
        repeat (60) cyc();
        #3 rst_L = 1'b0;
        #1;
        model_reset();
        check("rst_allpot", 64'(allpot), 64'h0);
        check("rst_rel", 64'(pot_rel), 64'h0);
        check("rst_ctr", 64'(bin_ctr_pot), 64'h0);
        check("rst_val", 64'(pot_val), 64'h0);
        compare();
        @(posedge o2);
        #1;
        compare();
        rst_L = 1'b1;
        repeat (20) cyc();
        check("post_rst_ctr", 64'(bin_ctr_pot), 64'h0);
        check("post_rst_allpot", 64'(allpot), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
